// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the DMEM arbiter.
//   arb_state_e : owner of DMEM in the previous cycle (FSM state)
//   owner_e     : winner of the current cycle; the ControlUnit stall logic
//                 uses the same constants
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU      = 2'd1,
    DMA      = 2'd2,
    DMA_LOCK = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_arb_fsm.sv
// Ownership FSM for the DMEM arbiter.
//   clk, rst_n          : clock, asynchronous active-low reset
//   cpu_req, dma_req    : current-cycle requests
//   dma_lock            : DMA asks to keep ownership across contention
//   owner               : combinational winner for this cycle (OWN_NONE in reset)
// Contention alternates with the previous owner. A locked DMA keeps the bus
// for up to BURST_MAX contended beats before the CPU gets one.
module dmem_arb_fsm
  import dmem_arbiter_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   cpu_req,
  input  logic   dma_req,
  input  logic   dma_lock,
  output owner_e owner
);

  localparam int BW = $clog2(BURST_MAX + 1);

  arb_state_e    state_q, state_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic          dma_pref;

  // On contention DMA wins only right after a CPU beat, or while a locked
  // burst is still within its budget.
  always_comb begin
    dma_pref = (state_q == CPU) ||
               (state_q == DMA_LOCK && dma_lock && burst_cnt_q < BW'(BURST_MAX));
    owner = OWN_NONE;
    if (!rst_n)                  owner = OWN_NONE;  // grants dead while in reset
    else if (cpu_req && dma_req) owner = dma_pref ? OWN_DMA : OWN_CPU;
    else if (cpu_req)            owner = OWN_CPU;
    else if (dma_req)            owner = OWN_DMA;
  end

  always_comb begin
    state_d     = IDLE;
    burst_cnt_d = '0;
    case (owner)
      OWN_CPU: begin
        state_d     = CPU;
        burst_cnt_d = '0;
      end
      OWN_DMA: begin
        state_d     = dma_lock ? DMA_LOCK : DMA;
        burst_cnt_d = burst_cnt_q;
        // only beats that actually held off the CPU consume the budget
        if (dma_lock && cpu_req && burst_cnt_q < BW'(BURST_MAX))
          burst_cnt_d = burst_cnt_q + 1'b1;
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port DMEM arbiter between the CPU datapath and a DMA/loader.
//   Clock, Reset_n                        : clock, async active-low reset
//   cpu_req/we/addr/wdata, cpu_rdata      : CPU side (ALU_Out, ReadData2, MemRW)
//   cpu_stall                             : CPU requested but was denied
//   dma_req/lock/we/addr/wdata, dma_rdata : DMA side
//   dma_gnt                               : DMA owns DMEM this cycle
//   mem_addr/wdata/we, mem_rdata          : to/from DMEM (comb read, clocked write)
//   stall_cnt                             : saturating count of stall cycles
// The grant is combinational so a winning CPU sees no extra latency.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 16
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_lock,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  stall_cnt
);

  owner_e           owner;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  dmem_arb_fsm #(.BURST_MAX(BURST_MAX)) u_fsm (
    .clk      (Clock),
    .rst_n    (Reset_n),
    .cpu_req  (cpu_req),
    .dma_req  (dma_req),
    .dma_lock (dma_lock),
    .owner    (owner)
  );

  // Owner is OWN_NONE in reset, so every output below falls to zero there.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    cpu_rdata = '0;
    dma_rdata = '0;
    case (owner)
      OWN_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we & cpu_req;
        cpu_rdata = mem_rdata;
      end
      OWN_DMA: begin
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_we    = dma_we & dma_req;
        dma_rdata = mem_rdata;
      end
      default: ;
    endcase
  end

  assign dma_gnt   = (owner == OWN_DMA);
  assign cpu_stall = cpu_req & Reset_n & (owner != OWN_CPU);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cpu_stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: the stimulus process drives requests
// just after each rising edge and pushes the reference model's expected
// outputs; the monitor pops and compares on the falling edge.
module tb_dmem_arbiter;

  localparam int BM    = 4;
  localparam int CNT_W = 4;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_lock = 0, dma_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, dma_gnt, mem_we;
  logic [CNT_W-1:0] stall_cnt;

  always #5 Clock = ~Clock;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_MAX(BM), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_gnt(dma_gnt),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );

  // DMEM: 16 words, combinational read, clocked write
  logic [31:0] dmem [16];
  assign mem_rdata = dmem[mem_addr[5:2]];
  always @(posedge Clock) if (mem_we) dmem[mem_addr[5:2]] <= mem_wdata;

  typedef struct {
    logic        stall, gnt, we;
    logic [31:0] addr, wdata, crd, drd;
    int          cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;

  // Reference model: who owned the bus last cycle, whether that DMA beat was
  // locked, and how many locked beats have kept the CPU waiting.
  int          last_own = 0;  // 0 none, 1 cpu, 2 dma
  bit          last_locked = 0;
  int          run = 0;
  int          scnt = 0;
  logic [31:0] ref_mem [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  always @(negedge Clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, e.stall});
      chk("dma_gnt",   {31'd0, dma_gnt},   {31'd0, e.gnt});
      chk("mem_we",    {31'd0, mem_we},    {31'd0, e.we});
      chk("mem_addr",  mem_addr,  e.addr);
      chk("mem_wdata", mem_wdata, e.wdata);
      chk("cpu_rdata", cpu_rdata, e.crd);
      chk("dma_rdata", dma_rdata, e.drd);
      chk("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
    end
  end

  task automatic drive(input bit cr, input bit cwe, input logic [31:0] ca, input logic [31:0] cd,
                       input bit dr, input bit dl, input bit dwe, input logic [31:0] da,
                       input logic [31:0] dd);
    exp_t e;
    bit   cw, dw, dma_first;
    @(posedge Clock); #1;
    Reset_n = 1; cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_lock = dl; dma_we = dwe; dma_addr = da; dma_wdata = dd;
    // alternate after a CPU beat; a locked DMA keeps going within its budget
    dma_first = (last_own == 1) || (last_own == 2 && last_locked && dl && run < BM);
    cw = cr && (!dr || !dma_first);
    dw = dr && !cw;
    e.stall = cr && !cw;
    e.gnt   = dw;
    e.we    = cw ? cwe : (dw ? dwe : 1'b0);
    e.addr  = cw ? ca : (dw ? da : 32'd0);
    e.wdata = cw ? cd : (dw ? dd : 32'd0);
    e.crd   = cw ? ref_mem[ca[5:2]] : 32'd0;
    e.drd   = dw ? ref_mem[da[5:2]] : 32'd0;
    e.cnt   = scnt;
    q.push_back(e);
    if (e.we) ref_mem[e.addr[5:2]] = e.wdata;
    if (e.stall && scnt < (1 << CNT_W) - 1) scnt++;
    if (cw) begin
      last_own = 1; run = 0;
    end else if (dw) begin
      last_own = 2; last_locked = dl;
      if (dl && cr && run < BM) run++;
    end else begin
      last_own = 0; run = 0;
    end
  endtask

  // Reset asserted between edges with both sides requesting: all outputs zero.
  task automatic rst_mid();
    exp_t e;
    @(posedge Clock); #3;
    Reset_n = 0; cpu_req = 1; dma_req = 1; dma_lock = 1; cpu_we = 1; dma_we = 1;
    e = '{stall: 0, gnt: 0, we: 0, addr: 0, wdata: 0, crd: 0, drd: 0, cnt: 0};
    q.push_back(e);
    last_own = 0; last_locked = 0; run = 0; scnt = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin dmem[i] = '0; ref_mem[i] = '0; end
    rst_mid();
    // CPU only: write then read back 0x10
    drive(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    drive(1, 0, 32'h10, 32'h0, 0, 0, 0, 0, 0);
    // Alternation from reset: CPU, DMA, CPU, DMA
    rst_mid();
    for (int i = 0; i < 4; i++) drive(1, 0, 32'h10, 0, 1, 0, 0, 32'h4, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Locked burst from state CPU: DMAx4, CPU, DMAx4, CPU
    rst_mid();
    drive(1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(1, 0, 32'h10, 0, 1, 1, 0, 32'(i % 16) << 2, 0);
    // DMA write during CPU stall: only 0x20 written, then CPU store to 0x24
    drive(1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 32'h24, 32'hAAAA5555, 1, 0, 1, 32'h20, 32'h1234);
    drive(1, 0, 32'h24, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 32'h20, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 32'h24, 32'hAAAA5555, 0, 0, 0, 0, 0);
    drive(1, 0, 32'h24, 0, 0, 0, 0, 0, 0);
    // Reset mid-burst, then CPU wins first contention
    drive(1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 32'h0, 0, 1, 1, 0, 32'h8, 0);
    drive(1, 0, 32'h0, 0, 1, 1, 1, 32'h8, 32'h77);
    rst_mid();
    drive(1, 0, 32'h8, 0, 1, 1, 0, 32'hC, 0);
    drive(1, 0, 32'h8, 0, 1, 1, 0, 32'hC, 0);
    // Saturation: 20 contended locked cycles, 16 stalls, 4-bit counter caps at 15
    rst_mid();
    for (int i = 0; i < 20; i++) drive(1, 0, 32'h4, 0, 1, 1, 0, 32'h8, 0);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) rst_mid();
      else drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 32'($urandom_range(0, 15)) << 2, $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 1) == 1, 32'($urandom_range(0, 15)) << 2, $urandom);
    end
    @(posedge Clock); @(negedge Clock); #1;
    chk("drain", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
